// File: rtl/tug_of_war_match.sv
// tug_of_war_match: two-player tug-of-war match engine.
//
// Raw active-low keys are synchronised and edge-detected into one-cycle
// pulses. A lone p1 pulse moves the light toward bit LEDS-1. A lone p2 pulse
// moves it toward bit 0. Pulling off either end scores a round for that
// player and recentres the light. The first player to reach WIN_ROUNDS ends
// the match. Only reset leaves the finished state.
//
// Optional feature: define CPU_PLAYER_EN to replace player 2 with an
// LFSR-driven computer opponent whose pull rate is set by cpu_level.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   p1_n, p2_n  raw player keys, active-low, asynchronous to clk
//   cpu_level   computer aggressiveness (CPU_PLAYER_EN builds only)
//   leds        one-hot light position, zero once the match is over
//   hex_p1/p2   score digits, active-low segments {g,f,e,d,c,b,a}
//   match_over  high once a player has won
//   winner      2'b10 player 1, 2'b01 player 2, 2'b00 none
module tug_of_war_match #(
    parameter int unsigned LEDS       = 9,
    parameter int unsigned WIN_ROUNDS = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            p1_n,
    input  logic            p2_n,
    input  logic [9:0]      cpu_level,
    output logic [LEDS-1:0] leds,
    output logic [6:0]      hex_p1,
    output logic [6:0]      hex_p2,
    output logic            match_over,
    output logic [1:0]      winner
);
    localparam int unsigned   PW       = $clog2(LEDS);
    localparam logic [PW-1:0] Centre   = PW'((LEDS - 1) / 2);
    localparam logic [PW-1:0] PosMax   = PW'(LEDS - 1);
    localparam logic [3:0]    ScoreWin = 4'(WIN_ROUNDS);

    typedef enum logic [0:0] {StPlay, StOver} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [3:0]    score1_q, score1_d;
    logic [3:0]    score2_q, score2_d;
    logic [1:0]    winner_q, winner_d;

    // Player 1 input path, levels held in pressed-high sense.
    logic p1_meta_q, p1_sync_q, p1_prev_q;
    logic p1_press, p2_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_meta_q <= 1'b0;
            p1_sync_q <= 1'b0;
            p1_prev_q <= 1'b0;
        end else begin
            p1_meta_q <= ~p1_n;
            p1_sync_q <= p1_meta_q;
            p1_prev_q <= p1_sync_q;
        end
    end
    assign p1_press = p1_sync_q & ~p1_prev_q;

`ifdef CPU_PLAYER_EN
    logic [9:0] lfsr_q;
    logic       unused_p2_n;

    assign unused_p2_n = p2_n;

    // XNOR feedback, so the all-zero reset value is a legal running state.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};
        end
    end
    assign p2_press = (lfsr_q < cpu_level);
`else
    logic p2_meta_q, p2_sync_q, p2_prev_q;
    logic unused_cpu_level;

    assign unused_cpu_level = ^cpu_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            p2_meta_q <= 1'b0;
            p2_sync_q <= 1'b0;
            p2_prev_q <= 1'b0;
        end else begin
            p2_meta_q <= ~p2_n;
            p2_sync_q <= p2_meta_q;
            p2_prev_q <= p2_sync_q;
        end
    end
    assign p2_press = p2_sync_q & ~p2_prev_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StPlay;
            pos_q    <= Centre;
            score1_q <= 4'd0;
            score2_q <= 4'd0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        // Simultaneous pulses cancel; only a lone pulse acts.
        if (state_q == StPlay && (p1_press ^ p2_press)) begin
            if (p1_press) begin
                if (pos_q == PosMax) begin
                    score1_d = score1_q + 4'd1;
                    pos_d    = Centre;
                    if (score1_d == ScoreWin) begin
                        state_d  = StOver;
                        winner_d = 2'b10;
                    end
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    score2_d = score2_q + 4'd1;
                    pos_d    = Centre;
                    if (score2_d == ScoreWin) begin
                        state_d  = StOver;
                        winner_d = 2'b01;
                    end
                end else begin
                    pos_d = pos_q - PW'(1);
                end
            end
        end
    end

    function automatic logic [6:0] hex_digit(input logic [3:0] d);
        case (d)
            4'd0:    hex_digit = 7'b1000000;
            4'd1:    hex_digit = 7'b1111001;
            4'd2:    hex_digit = 7'b0100100;
            4'd3:    hex_digit = 7'b0110000;
            4'd4:    hex_digit = 7'b0011001;
            4'd5:    hex_digit = 7'b0010010;
            4'd6:    hex_digit = 7'b0000010;
            4'd7:    hex_digit = 7'b1111000;
            4'd8:    hex_digit = 7'b0000000;
            4'd9:    hex_digit = 7'b0010000;
            default: hex_digit = 7'b1111111;
        endcase
    endfunction

    assign leds       = (state_q == StOver) ? '0 : ({{(LEDS-1){1'b0}}, 1'b1} << pos_q);
    assign hex_p1     = hex_digit(score1_q);
    assign hex_p2     = hex_digit(score2_q);
    assign match_over = (state_q == StOver);
    assign winner     = winner_q;

endmodule

// File: tb/tb_tug_of_war_match.sv
// Testbench for tug_of_war_match (LEDS=9, WIN_ROUNDS=2). Directed steps plus
// randomized key activity, checked against a behavioural model of the game.
module tb_tug_of_war_match;
    localparam int unsigned LEDS       = 9;
    localparam int unsigned WIN_ROUNDS = 2;
    localparam int          C          = (LEDS - 1) / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b0;
    logic            p1_n  = 1'b1;
    logic            p2_n  = 1'b1;
    logic [9:0]      cpu_level = '0;
    logic [LEDS-1:0] leds;
    logic [6:0]      hex_p1, hex_p2;
    logic            match_over;
    logic [1:0]      winner;

    tug_of_war_match #(
        .LEDS       (LEDS),
        .WIN_ROUNDS (WIN_ROUNDS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p1_n       (p1_n),
        .p2_n       (p2_n),
        .cpu_level  (cpu_level),
        .leds       (leds),
        .hex_p1     (hex_p1),
        .hex_p2     (hex_p2),
        .match_over (match_over),
        .winner     (winner)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model of the game.
    int         m_pos  = C;
    int         m_s1   = 0;
    int         m_s2   = 0;
    bit         m_over = 1'b0;
    logic [1:0] m_win  = 2'b00;
    logic [9:0] m_lfsr = '0;
    // Pressed-sense key samples taken at each edge, newest first.
    bit         hist1 [$] = '{1'b0, 1'b0, 1'b0};
    bit         hist2 [$] = '{1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit k1, input bit k2, input bit rst);
        bit pu1, pu2;
        // A key acts at the edge two samples after it is first seen down.
        pu1 = hist1[1] && !hist1[2];
`ifdef CPU_PLAYER_EN
        pu2 = (m_lfsr < cpu_level);
`else
        pu2 = hist2[1] && !hist2[2];
`endif
        if (rst) begin
            m_pos  = C;
            m_s1   = 0;
            m_s2   = 0;
            m_over = 1'b0;
            m_win  = 2'b00;
            m_lfsr = '0;
            hist1  = '{1'b0, 1'b0, 1'b0};
            hist2  = '{1'b0, 1'b0, 1'b0};
        end else begin
            if (!m_over && pu1 != pu2) begin
                if (pu1) begin
                    if (m_pos == LEDS - 1) begin
                        m_s1++;
                        m_pos = C;
                        if (m_s1 == WIN_ROUNDS) begin
                            m_over = 1'b1;
                            m_win  = 2'b10;
                        end
                    end else begin
                        m_pos++;
                    end
                end else begin
                    if (m_pos == 0) begin
                        m_s2++;
                        m_pos = C;
                        if (m_s2 == WIN_ROUNDS) begin
                            m_over = 1'b1;
                            m_win  = 2'b01;
                        end
                    end else begin
                        m_pos--;
                    end
                end
            end
            hist1.push_front(k1);
            void'(hist1.pop_back());
            hist2.push_front(k2);
            void'(hist2.pop_back());
            m_lfsr = {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
        end
    endtask

    task automatic check_model(input string where);
        check({where, ".leds"}, 32'(leds), m_over ? 32'd0 : (32'd1 << m_pos));
        check({where, ".hex_p1"}, 32'(hex_p1), 32'(seg[m_s1]));
        check({where, ".hex_p2"}, 32'(hex_p2), 32'(seg[m_s2]));
        check({where, ".match_over"}, 32'(match_over), 32'(m_over));
        check({where, ".winner"}, 32'(winner), 32'(m_win));
    endtask

    // One clock: drive keys (pressed-high sense) and reset, then check.
    task automatic step(input bit k1, input bit k2, input bit rst, input string tag);
        @(negedge clk);
        p1_n  = ~k1;
        p2_n  = ~k2;
        reset = rst;
        @(posedge clk);
        model_edge(k1, k2, rst);
        #1;
        check_model(tag);
    endtask

    task automatic press(input bit k1, input bit k2, input string tag);
        step(k1, k2, 1'b0, tag);
        step(k1, k2, 1'b0, tag);
        step(1'b0, 1'b0, 1'b0, tag);
        step(1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".leds"}, 32'(leds), 32'b000010000);
        check({tag, ".hex_p1"}, 32'(hex_p1), 32'b1000000);
        check({tag, ".hex_p2"}, 32'(hex_p2), 32'b1000000);
        check({tag, ".match_over"}, 32'(match_over), 32'd0);
        check({tag, ".winner"}, 32'(winner), 32'd0);
    endtask

    initial begin
        bit lvl1, lvl2, seen;
        int t1, t2;

        // Reset values.
        step(1'b0, 1'b0, 1'b1, "reset");
        check_reset_values("reset_const");

        // Held key: one move, two edges after the first low sample.
        step(1'b1, 1'b0, 1'b0, "hold_k");
        check("hold_k0", 32'(leds), 32'b000010000);
        step(1'b1, 1'b0, 1'b0, "hold_k1");
        check("hold_k1", 32'(leds), 32'b000010000);
        step(1'b1, 1'b0, 1'b0, "hold_k2");
        check("hold_k2", 32'(leds), 32'b000100000);
        step(1'b1, 1'b0, 1'b0, "hold_k3");
        repeat (3) step(1'b0, 1'b0, 1'b0, "hold_rel");
        check("hold_once", 32'(leds), 32'b000100000);

        // Scoring and match end.
        step(1'b0, 1'b0, 1'b1, "reset2");
        repeat (5) press(1'b1, 1'b0, "score1");
        check("round1_hex_p1", 32'(hex_p1), 32'b1111001);
        check("round1_leds", 32'(leds), 32'b000010000);
        repeat (5) press(1'b1, 1'b0, "score2");
        check("over_match", 32'(match_over), 32'd1);
        check("over_winner", 32'(winner), 32'b10);
        check("over_leds", 32'(leds), 32'd0);
        check("over_hex_p1", 32'(hex_p1), 32'b0100100);

        // Presses in the finished state change nothing.
        repeat (2) press(1'b1, 1'b1, "over_both");
        repeat (2) press(1'b0, 1'b1, "over_p2");
        repeat (2) press(1'b1, 1'b0, "over_p1");
        check("frozen_match", 32'(match_over), 32'd1);
        check("frozen_winner", 32'(winner), 32'b10);
        check("frozen_leds", 32'(leds), 32'd0);
        check("frozen_hex_p1", 32'(hex_p1), 32'b0100100);
        check("frozen_hex_p2", 32'(hex_p2), 32'b1000000);
        step(1'b0, 1'b0, 1'b1, "over_reset");
        check_reset_values("over_reset_const");

`ifndef CPU_PLAYER_EN
        // Simultaneous pulses cancel.
        repeat (3) press(1'b1, 1'b1, "simul");
        check("simul_leds", 32'(leds), 32'b000010000);
        check("simul_hex_p1", 32'(hex_p1), 32'b1000000);
        check("simul_hex_p2", 32'(hex_p2), 32'b1000000);

        // Reset beats a pulse on the same edge.
        step(1'b0, 1'b0, 1'b1, "reset3");
        repeat (5) press(1'b0, 1'b1, "p2_round");
        check("mid_hex_p2", 32'(hex_p2), 32'b1111001);
        repeat (3) press(1'b1, 1'b0, "to_pos7");
        check("mid_pos7", 32'(leds), 32'b010000000);
        step(1'b1, 1'b0, 1'b0, "mid_k");
        step(1'b1, 1'b0, 1'b0, "mid_k1");
        step(1'b0, 1'b0, 1'b1, "mid_rst");
        check_reset_values("mid_rst_const");
        repeat (3) step(1'b0, 1'b0, 1'b0, "mid_after");
        check("mid_no_leak", 32'(leds), 32'b000010000);

        // Randomized play.
        for (int s = 0; s < 6; s++) begin
            step(1'b0, 1'b0, 1'b1, "rnd_reset");
            lvl1 = 1'b0;
            lvl2 = 1'b0;
            t1 = (s % 2 == 0) ? 50 : 20;
            t2 = (s % 2 == 0) ? 20 : 50;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 99) < t1) lvl1 = ~lvl1;
                if ($urandom_range(0, 99) < t2) lvl2 = ~lvl2;
                step(lvl1, lvl2, ($urandom_range(0, 149) == 0), "rnd");
            end
        end
`else
        // Idle computer never pulls.
        cpu_level = 10'd0;
        step(1'b0, 1'b0, 1'b1, "cpu0_reset");
        repeat (1000) step(1'b0, 1'b0, 1'b0, "cpu0");
        check("cpu0_leds", 32'(leds), 32'b000010000);
        check("cpu0_hex_p2", 32'(hex_p2), 32'b1000000);

        // Maximum aggressiveness scores within 6 cycles.
        cpu_level = 10'h3FF;
        step(1'b0, 1'b0, 1'b1, "cpumax_reset");
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step(1'b0, 1'b0, 1'b0, "cpumax");
            if (hex_p2 == 7'b1111001) seen = 1'b1;
        end
        check("cpumax_point", 32'(seen), 32'd1);

        // Randomized play against the computer.
        for (int s = 0; s < 6; s++) begin
            cpu_level = 10'($urandom_range(0, 300));
            step(1'b0, 1'b0, 1'b1, "rnd_reset");
            lvl1 = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 99) < 50) lvl1 = ~lvl1;
                step(lvl1, 1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0), "rnd");
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tug_of_war_match.md
# tug_of_war_match

Parametrised two-player tug-of-war match engine for the DE1-SoC labs, replacing the fixed 9-LED single-round game path. It takes raw active-low pushbuttons, synchronises them and turns each press into a one-cycle pulse. It moves a one-hot light across a configurable LED bar and keeps per-player round scores on two seven-segment digits until one player reaches the match target. An optional computer opponent can take over player 2.

## Interface

- `LEDS`, 9, playfield width; odd, 3..31; centre index `C = (LEDS-1)/2`
- `WIN_ROUNDS`, 7, rounds needed to win the match; 1..9
- `clk`  in  1  system clock (CLOCK_50 at top level)
- `reset`  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high
- `p1_n`  in  1  raw player-1 key, active-low, asynchronous to `clk`
- `p2_n`  in  1  raw player-2 key, active-low, asynchronous to `clk`
- `cpu_level`  in  10  computer aggressiveness; ignored unless `CPU_PLAYER_EN` is defined
- `leds`  out  LEDS  one-hot light position; bit `LEDS-1` is player 1's end
- `hex_p1`  out  7  player-1 score, active-low segments {g,f,e,d,c,b,a}
- `hex_p2`  out  7  player-2 score, same encoding
- `match_over`  out  1  high once a player reaches `WIN_ROUNDS`
- `winner`  out  2  2'b00 none, 2'b10 player 1, 2'b01 player 2

## Operation

- Input path, per key: two-flop synchroniser, then a previous-level flop. `press = sync & ~prev`, with levels in pressed-high sense. A held key yields exactly one pulse.
- Position register `pos`, range 0..LEDS-1. `leds = 1 << pos`, except in OVER (see below).
- A lone p1 pulse increments `pos`; a lone p2 pulse decrements it. Simultaneous p1 and p2 pulses: no change.
- State PLAY:
  - lone p1 pulse with `pos == LEDS-1`: `score1 += 1`, `pos <= C`
  - lone p2 pulse with `pos == 0`: `score2 += 1`, `pos <= C`
  - if the incremented score equals `WIN_ROUNDS`, go to OVER on the same edge
- State OVER:
  - all pulses ignored; `leds = 0`; `match_over = 1`
  - `winner` holds the scorer; scores are frozen
  - exit only via `reset`
- Scores are 4-bit, never exceed `WIN_ROUNDS`, and do not wrap.
- Hex encoding, digits 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

## Timing

- Reset values:
  - `pos = C`, `leds = 1 << C`
  - scores 0, so `hex_p1 = hex_p2 = 7'b1000000`
  - `match_over = 0`, `winner = 2'b00`
  - state PLAY; synchroniser and prev flops in the released state; LFSR 0
- Press latency: raw key low sampled at edge k, so the synchroniser output is pressed after k+1. The pulse is high during the cycle after k+1, and `pos`/score update at edge k+2.
- A key held through reset deassertion registers one press two edges after release of `reset`.
- Reset asserted mid-round or in OVER takes effect at the next edge and overrides any pulse in that cycle.
- Scoring and recentring happen on the same edge; the scoring pulse does not also move the light.

## Configuration

- `CPU_PLAYER_EN` defined:
  - player 2 is the computer and `p2_n` is ignored
  - 10-bit LFSR advances every cycle, reset to 0, `next = {lfsr[8:0], ~(lfsr[9] ^ lfsr[6])}`
  - CPU pulse is high in any cycle where `lfsr < cpu_level` (unsigned), applied directly with no synchroniser
  - `cpu_level = 0` means the computer never pulls
- `CPU_PLAYER_EN` undefined: there is no LFSR logic, `cpu_level` is unused, and player 2 comes from `p2_n` through the normal input path.

## Test plan

- Reset, then hold `p1_n` low for 4 cycles → exactly one move: `leds` goes from 9'b000010000 to 9'b000100000, two edges after the first low sample.
- LEDS=9, WIN_ROUNDS=2, five separated p1 presses → after the 5th, `hex_p1 = 7'b1111001` and `leds = 9'b000010000`. Five more presses → `match_over = 1`, `winner = 2'b10`, `leds = 0`.
- p1 and p2 pulses landing on the same edge, repeated 3 times → `pos` stays at 4 and scores stay 0.
- In OVER, further presses on both keys → all outputs unchanged. Assert `reset` for 1 cycle → all reset values restored.
- Mid-round, with `pos = 7` and `score2 = 1`, assert `reset` together with a p1 pulse → `pos = 4`, both scores 0, no score increment.
- With `CPU_PLAYER_EN` and `cpu_level = 0`: 1000 cycles with p1 idle → `pos` stays at 4. With `cpu_level = 10'h3FF` and p1 idle → a point for player 2 within 6 cycles (`hex_p2 = 7'b1111001`).
